// File: rtl/pipeline_ctrl.sv
// Hazard/redirect sequencer for the 5-stage pipeline: combinational stall/flush/pc_sel from state and inputs.
// Zero-latency controls, applied at the next posedge; a redirect during a busy fetch waits for ifetch_done.
module pipeline_ctrl #(
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ifetch_busy,
  input  logic             ifetch_done,
  input  logic             mem_busy,
  input  logic             ex_busy,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic             pc_sel,
  output logic [PC_W-1:0]  pc_redirect,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic {RUN, REDIR_WAIT} state_t;

  state_t            state, stateNext;
  logic [PC_W-1:0]   savedPc, savedPcNext;
  logic [CNT_W-1:0]  redirectCnt;
  logic              cntInc;
  logic              loadUse;

  assign redirect_cnt = redirectCnt;
  assign loadUse = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_comb begin
    stateNext   = state;
    savedPcNext = savedPc;
    cntInc      = 1'b0;
    stallF      = 1'b0;
    stallD      = 1'b0;
    stallE      = 1'b0;
    stallM      = 1'b0;
    flushD      = 1'b0;
    flushE      = 1'b0;
    flushM      = 1'b0;
    flushW      = 1'b0;
    pc_sel      = 1'b0;
    pc_redirect = '0;

    case (state)
      RUN: begin
        if (mem_busy) begin
          {stallF, stallD, stallE, stallM} = 4'b1111;
          flushW = 1'b1;
        end else if (ex_busy) begin
          {stallF, stallD, stallE} = 3'b111;
          flushM = 1'b1;
        end else if (redirect_valid && (!ifetch_busy || ifetch_done)) begin
          flushD      = 1'b1;
          flushE      = 1'b1;
          pc_sel      = 1'b1;
          pc_redirect = redirect_pc;
          cntInc      = 1'b1;
        end else if (redirect_valid) begin
          // Fetch still in flight: park the target until the stale fetch returns.
          flushD      = 1'b1;
          flushE      = 1'b1;
          stallF      = 1'b1;
          savedPcNext = redirect_pc;
          stateNext   = REDIR_WAIT;
        end else if (loadUse) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end else if (ifetch_busy) begin
          stallF = 1'b1;
          flushD = 1'b1;
        end
      end
      REDIR_WAIT: begin
        stallF = 1'b1;
        flushD = 1'b1;
        if (mem_busy) begin
          {stallF, stallD, stallE, stallM} = 4'b1111;
          flushW = 1'b1;
        end else if (ex_busy) begin
          {stallF, stallD, stallE} = 3'b111;
          flushM = 1'b1;
        end
        if (ifetch_done) begin
          stallF      = 1'b0;
          pc_sel      = 1'b1;
          pc_redirect = savedPc;
          cntInc      = 1'b1;
          stateNext   = RUN;
        end
      end
      default: stateNext = RUN;
    endcase

    // A held stage must keep its contents, so its bubble is suppressed.
    flushD = flushD & ~stallD;
    flushE = flushE & ~stallE;
    flushM = flushM & ~stallM;

    if (reset) begin
      {stallF, stallD, stallE, stallM} = 4'b0000;
      {flushD, flushE, flushM, flushW} = 4'b1111;
      pc_sel      = 1'b0;
      pc_redirect = '0;
      cntInc      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      savedPc     <= '0;
      redirectCnt <= '0;
    end else begin
      state   <= stateNext;
      savedPc <= savedPcNext;
      if (cntInc) redirectCnt <= redirectCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed literal checks plus randomized traffic against a rule-level model.
module tb_pipeline_ctrl;

  localparam int PC_W  = 64;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             ifetch_busy, ifetch_done, mem_busy, ex_busy;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             ex_memread, redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             stallF, stallD, stallE, stallM;
  logic             flushD, flushE, flushM, flushW, pc_sel;
  logic [PC_W-1:0]  pc_redirect;
  logic [CNT_W-1:0] redirect_cnt;

  int assertions = 0;
  int failures   = 0;
  bit running    = 1'b0;

  // Model state: whether a redirect is parked behind a busy fetch, its target, and the count.
  bit              mWaiting = 1'b0;
  logic [PC_W-1:0] mTarget  = '0;
  logic [CNT_W-1:0] mCnt    = '0;

  logic [8:0] outVec;
  assign outVec = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, pc_sel};

  always #5 clk = ~clk;

  pipeline_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ifetch_busy(ifetch_busy), .ifetch_done(ifetch_done),
    .mem_busy(mem_busy), .ex_busy(ex_busy),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .pc_sel(pc_sel), .pc_redirect(pc_redirect), .redirect_cnt(redirect_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    ifetch_busy = 0; ifetch_done = 0; mem_busy = 0; ex_busy = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_memread = 0;
    redirect_valid = 0; redirect_pc = '0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle reference: outputs from the current rules, then the model advances for the next edge.
  always @(negedge clk) begin
    bit [3:0] st, fl;  // st = {F,D,E,M}, fl = {D,E,M,W}
    bit sel, lu;
    logic [PC_W-1:0] red;
    if (running) begin
      st = '0; fl = '0; sel = 0; red = '0;
      lu = ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
      if (reset) begin
        fl = 4'b1111;
      end else begin
        if (mWaiting) begin st = 4'b1000; fl = 4'b1000; end
        if (mem_busy) begin st = 4'b1111; fl[0] = 1; end
        else if (ex_busy) begin st = 4'b1110; fl[1] = 1; end
        else if (!mWaiting) begin
          if (redirect_valid) begin
            fl = 4'b1100;
            if (ifetch_busy && !ifetch_done) st = 4'b1000;
            else begin sel = 1; red = redirect_pc; end
          end else if (lu) begin st = 4'b1100; fl = 4'b0100; end
          else if (ifetch_busy) begin st = 4'b1000; fl = 4'b1000; end
        end
        if (mWaiting && ifetch_done) begin st[3] = 0; sel = 1; red = mTarget; end
        for (int i = 0; i < 3; i++) if (st[2-i]) fl[3-i] = 0;
      end
      chk("ctrl_vec", outVec, {st, fl, sel});
      chk("pc_redirect", pc_redirect, red);
      chk("redirect_cnt", redirect_cnt, mCnt);
      if (reset) begin
        mWaiting = 0; mTarget = '0; mCnt = '0;
      end else if (mWaiting) begin
        if (ifetch_done) begin mWaiting = 0; mCnt = mCnt + 1'b1; end
      end else if (!mem_busy && !ex_busy && redirect_valid) begin
        if (ifetch_busy && !ifetch_done) begin mWaiting = 1; mTarget = redirect_pc; end
        else mCnt = mCnt + 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bubbles;
    reset = 1; idle();
    adv();
    running = 1;

    // Reset forcing
    @(negedge clk); chk("reset_vec", outVec, 9'b0000_1111_0);
    chk("reset_cnt", redirect_cnt, 8'd0);
    adv(); reset = 0;

    // Load-use, then the same with ex_rd = x0
    ex_memread = 1; ex_rd = 5; id_rs2 = 5;
    @(negedge clk); chk("load_use_vec", outVec, 9'b1100_0100_0);
    adv(); idle();
    @(negedge clk); chk("load_use_release", outVec, 9'b0);
    adv(); ex_memread = 1; ex_rd = 0;
    @(negedge clk); chk("load_use_x0", outVec, 9'b0);
    adv(); idle();

    // Idle redirect
    redirect_valid = 1; redirect_pc = 64'h8000_0100;
    @(negedge clk); chk("idle_redir_vec", outVec, 9'b0000_1100_1);
    chk("idle_redir_pc", pc_redirect, 64'h8000_0100);
    chk("idle_redir_cnt0", redirect_cnt, 8'd0);
    adv(); idle();
    @(negedge clk); chk("idle_redir_cnt1", redirect_cnt, 8'd1);
    adv();

    // Busy redirect: 3 wait cycles then ifetch_done
    redirect_valid = 1; redirect_pc = 64'h8000_0200; ifetch_busy = 1;
    @(negedge clk); chk("busy_redir_vec", outVec, 9'b1000_1100_0);
    adv(); redirect_valid = 0; redirect_pc = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("redir_wait_vec", outVec, 9'b1000_1000_0);
      adv();
    end
    ifetch_busy = 0; ifetch_done = 1;
    @(negedge clk); chk("redir_done_vec", outVec, 9'b0000_1000_1);
    chk("redir_done_pc", pc_redirect, 64'h8000_0200);
    adv(); idle();
    @(negedge clk); chk("busy_redir_cnt", redirect_cnt, 8'd2);
    adv();

    // Priority: mem_busy over redirect and load-use, then the held redirect applies
    mem_busy = 1; redirect_valid = 1; redirect_pc = 64'h8000_0300;
    ex_memread = 1; ex_rd = 7; id_rs1 = 7;
    @(negedge clk); chk("prio_mem_vec", outVec, 9'b1111_0001_0);
    adv(); mem_busy = 0;
    @(negedge clk); chk("prio_redir_vec", outVec, 9'b0000_1100_1);
    chk("prio_redir_pc", pc_redirect, 64'h8000_0300);
    adv(); idle();

    // ex_busy for 4 cycles
    bubbles = 0;
    for (int i = 0; i < 4; i++) begin
      ex_busy = 1;
      @(negedge clk); chk("ex_busy_vec", outVec, 9'b1110_0010_0);
      if (flushM) bubbles++;
      adv();
    end
    ex_busy = 0;
    @(negedge clk); if (flushM) bubbles++;
    chk("ex_busy_bubbles", bubbles, 4);
    chk("cnt_before_reset", redirect_cnt, 8'd3);
    adv();

    // mem_busy inside REDIR_WAIT: stallD wins over flushD
    redirect_valid = 1; redirect_pc = 64'h8000_0500; ifetch_busy = 1;
    adv(); redirect_valid = 0; mem_busy = 1;
    @(negedge clk); chk("wait_mem_vec", outVec, 9'b1111_0001_0);
    adv(); mem_busy = 0;

    // Reset while waiting abandons the redirect
    reset = 1;
    @(negedge clk); chk("wait_reset_vec", outVec, 9'b0000_1111_0);
    adv(); reset = 0; ifetch_busy = 0; ifetch_done = 1;
    @(negedge clk); chk("post_reset_done_vec", outVec, 9'b0);
    chk("post_reset_cnt", redirect_cnt, 8'd0);
    adv(); idle();
    @(negedge clk); chk("post_reset_cnt_hold", redirect_cnt, 8'd0);
    adv();

    // Counter wrap
    redirect_valid = 1;
    for (int i = 0; i < 255; i++) begin
      redirect_pc = 64'h1000 + 64'(i);
      adv();
    end
    redirect_valid = 0;
    @(negedge clk); chk("cnt_max", redirect_cnt, 8'hFF);
    adv(); redirect_valid = 1;
    adv(); redirect_valid = 0;
    @(negedge clk); chk("cnt_wrap", redirect_cnt, 8'h00);
    adv();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(63) == 0);
      mem_busy       = ($urandom_range(5) == 0);
      ex_busy        = ($urandom_range(5) == 0);
      redirect_valid = ($urandom_range(3) == 0);
      ifetch_busy    = ($urandom_range(2) == 0);
      ifetch_done    = ($urandom_range(3) == 0);
      ex_memread     = ($urandom_range(2) == 0);
      ex_rd          = 5'($urandom_range(3));
      id_rs1         = 5'($urandom_range(3));
      id_rs2         = 5'($urandom_range(3));
      redirect_pc    = {$urandom, $urandom};
      adv();
    end

    running = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the five-stage pipeline. It drives the stall and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the fetch PC-redirect select. It resolves multi-cycle memory and execute waits, load-use hazards and branch/jump redirects, including redirects that arrive while an instruction fetch is still outstanding. It also keeps a redirect event counter.

## Interface

Parameters:
- PC_W, 64, PC width.
- CNT_W, 32, width of the redirect counter.

Ports:
- clk  in  1  system clock; everything registered on posedge.
- reset  in  1  synchronous, active-high reset.
- ifetch_busy  in  1  instruction fetch outstanding this cycle (no instruction delivered).
- ifetch_done  in  1  fetch data returns this cycle.
- mem_busy  in  1  MEM-stage data access outstanding.
- ex_busy  in  1  EX multi-cycle unit (mul/div) not finished.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- ex_rd  in  5  destination of the instruction in EX.
- ex_memread  in  1  EX instruction is a load.
- redirect_valid  in  1  EX resolved a taken branch/jump or misprediction.
- redirect_pc  in  PC_W  target PC.
- stallF, stallD, stallE, stallM  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- flushD, flushE, flushM, flushW  out  1  load bubble into IF/ID, ID/EX, EX/MEM, MEM/WB.
- pc_sel  out  1  fetch takes pc_redirect next instead of sequential PC.
- pc_redirect  out  PC_W  redirect target.
- redirect_cnt  out  CNT_W  number of applied redirects, wraps.

## Operation

- Two-state FSM: RUN, REDIR_WAIT. Registers: state, saved_pc (PC_W), redirect_cnt.
- load_use = ex_memread & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
- RUN, evaluated in strict priority order; the first matching rule sets the outputs:
  1. mem_busy: stallF=stallD=stallE=stallM=1, flushW=1. A redirect is not accepted.
  2. ex_busy: stallF=stallD=stallE=1, flushM=1. A redirect is not accepted.
  3. redirect_valid with ifetch_busy=0: flushD=flushE=1, pc_sel=1, pc_redirect=redirect_pc, redirect_cnt+1.
  4. redirect_valid with ifetch_busy=1: flushD=flushE=1, stallF=1. Latch saved_pc=redirect_pc and go to REDIR_WAIT. No count yet.
  5. load_use: stallF=stallD=1, flushE=1.
  6. ifetch_busy: stallF=1, flushD=1.
  7. Otherwise all outputs 0.
- REDIR_WAIT:
  - stallF=1 and flushD=1 every cycle; the in-flight instruction is discarded.
  - On ifetch_done: pc_sel=1, pc_redirect=saved_pc, redirect_cnt+1, go to RUN. ifetch_done overrides stallF for that cycle so the new PC loads.
  - mem_busy or ex_busy additionally assert the matching stalls and bubbles from rules 1–2. They do not block the ifetch_done transition.
  - redirect_valid and load_use are ignored, because EX holds a bubble.
- Invariant: a stage's flush is never asserted together with its own stall.
  - If a stall rule applies to a stage, its flush is 0.
  - Example: in REDIR_WAIT with mem_busy, stallD=1 wins and flushD=0.
- pc_redirect is 0 whenever pc_sel=0.
- redirect_cnt wraps from 2^CNT_W−1 to 0.

## Timing

- All stall, flush and pc outputs are combinational from state and the current-cycle inputs; they take effect at the next posedge.
- Redirect with fetch idle: fetch starts at the target on the cycle after redirect_valid. Wrong-path penalty is 2 bubbles (D, E).
- Redirect with fetch busy: the target loads on the posedge ending the ifetch_done cycle.
- Load-use costs exactly 1 bubble; the stall is released once the load advances to MEM.
- Reset (takes effect at posedge):
  - state=RUN, saved_pc=0, redirect_cnt=0.
  - While reset is high, outputs are forced: flushD=flushE=flushM=flushW=1, all stalls 0, pc_sel=0, pc_redirect=0.
- Reset while in REDIR_WAIT abandons the pending redirect: no pc_sel, no count.
- Simultaneous redirect_valid and ifetch_done in RUN: treated as ifetch_busy=0, so rule 3 applies.

## Test plan

- Load-use: ex_memread=1, ex_rd=5, id_rs2=5 for 1 cycle → stallF=stallD=flushE=1 that cycle only. With ex_rd=0 → no stall.
- Idle redirect: redirect_valid=1, redirect_pc=0x8000_0100, ifetch_busy=0 → same cycle pc_sel=1, pc_redirect=0x8000_0100, flushD=flushE=1; redirect_cnt 0→1.
- Busy redirect:
  - redirect_pc=0x8000_0200 with ifetch_busy=1, then 3 busy cycles, then ifetch_done → REDIR_WAIT for 3 cycles with stallF=flushD=1.
  - On the done cycle: pc_sel=1, pc_redirect=0x8000_0200. The returned instruction never reaches ID.
- Priority: mem_busy=1 together with redirect_valid=1 and load_use → stallF/D/E/M=1, flushW=1, pc_sel=0. After mem_busy drops, the held redirect applies.
- ex_busy for 4 cycles → stallF/D/E=1, flushM=1 for exactly 4 cycles; EX/MEM bubble count is 4.
- Reset and wrap:
  - Reset asserted in REDIR_WAIT → next cycle RUN, redirect_cnt=0, no pc_sel on a later ifetch_done.
  - Preload redirect_cnt to 0xFFFF_FFFF (force), apply one redirect → 0.
